// File: rtl/gray_input_decoder.sv
// Gray-coded pin reader: two-flop synchroniser, stability filter, Gray-to-binary
// conversion and classification of each accepted change as up, down or skip.
module gray_input_decoder #(
    parameter int BITS      = 8,
    parameter int LOG2DELAY = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [BITS-1:0] gray_in,
    output logic [BITS-1:0] bin_out,
    output logic            valid,
    output logic            up,
    output logic            down,
    output logic            skip_err,
    output logic [7:0]      err_count
);

    localparam logic [LOG2DELAY-1:0] CNT_MAX = {LOG2DELAY{1'b1}};
    localparam logic [LOG2DELAY-1:0] CNT_ACC = {{(LOG2DELAY-1){1'b1}}, 1'b0};
    localparam logic [BITS-1:0]      ONE     = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic [BITS-1:0]      ALL1    = {BITS{1'b1}};

    logic [BITS-1:0]      s1, s2;
    logic [BITS-1:0]      cand;
    logic [LOG2DELAY-1:0] cnt;
    logic [BITS-1:0]      acc_gray;
    logic                 primed;

    logic                 accept;
    logic [BITS-1:0]      new_bin;
    logic [BITS-1:0]      diff;

    function automatic logic [BITS-1:0] gray2bin(input logic [BITS-1:0] g);
        logic [BITS-1:0] b;
        b[BITS-1] = g[BITS-1];
        for (int i = BITS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Accept fires on the edge where the counter reaches its maximum, so once per stable period.
    always_comb begin
        accept  = 1'b0;
        new_bin = gray2bin(cand);
        diff    = new_bin - bin_out;
        if ((s2 == cand) && (cnt == CNT_ACC)) begin
            accept = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            cnt  <= '0;
        end else begin
            s1 <= gray_in;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_gray  <= '0;
            primed    <= 1'b0;
            bin_out   <= '0;
            valid     <= 1'b0;
            up        <= 1'b0;
            down      <= 1'b0;
            skip_err  <= 1'b0;
            err_count <= '0;
        end else begin
            valid    <= 1'b0;
            up       <= 1'b0;
            down     <= 1'b0;
            skip_err <= 1'b0;
            if (accept) begin
                primed <= 1'b1;
                if (cand != acc_gray) begin
                    acc_gray <= cand;
                    bin_out  <= new_bin;
                    valid    <= 1'b1;
                    // The first word after reset only establishes a reference position.
                    if (primed) begin
                        if (diff == ONE) begin
                            up <= 1'b1;
                        end else if (diff == ALL1) begin
                            down <= 1'b1;
                        end else begin
                            skip_err <= 1'b1;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_input_decoder.sv
// Directed bench for gray_input_decoder at LOG2DELAY = 4 with a stable-run behavioural model
// checked every cycle, plus hand-computed expectations on individual steps.
module tb_gray_input_decoder;

    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] gray_in = 8'h00;
    logic [7:0] bin_out;
    logic       valid, up, down, skip_err;
    logic [7:0] err_count;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    gray_input_decoder #(.BITS(8), .LOG2DELAY(4)) dut (
        .clk(clk), .resetn(resetn), .gray_in(gray_in), .bin_out(bin_out),
        .valid(valid), .up(up), .down(down), .skip_err(skip_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] b2g(input int b);
        logic [7:0] v;
        v = 8'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) b = b ^ (g >> i);
        return b;
    endfunction

    // Model: the pin value seen two edges late must be presented for WIN consecutive edges.
    logic [7:0] m_p1 = 0, m_p2 = 0, m_last = 0, m_acc = 0, m_bin = 0;
    int         m_run = 1, m_err = 0;
    bit         m_primed = 0, m_valid = 0, m_up = 0, m_down = 0, m_skip = 0;

    always @(posedge clk or negedge resetn) begin
        logic [7:0] d;
        int step;
        if (!resetn) begin
            m_p1 = 0; m_p2 = 0; m_last = 0; m_run = 1; m_acc = 0; m_bin = 0;
            m_err = 0; m_primed = 0; m_valid = 0; m_up = 0; m_down = 0; m_skip = 0;
        end else begin
            d = m_p2; m_p2 = m_p1; m_p1 = gray_in;
            if (d == m_last) begin
                if (m_run <= WIN) m_run++;
            end else begin
                m_last = d; m_run = 1;
            end
            m_valid = 0; m_up = 0; m_down = 0; m_skip = 0;
            if (m_run == WIN) begin
                if (m_last != m_acc) begin
                    step = (int'(g2b(m_last)) - int'(m_bin) + 256) % 256;
                    m_valid = 1;
                    if (m_primed) begin
                        if (step == 1) m_up = 1;
                        else if (step == 255) m_down = 1;
                        else begin
                            m_skip = 1;
                            if (m_err < 255) m_err++;
                        end
                    end
                    m_acc = m_last;
                    m_bin = g2b(m_last);
                end
                m_primed = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if ({valid, up, down, skip_err} !== {m_valid, m_up, m_down, m_skip} ||
                bin_out !== m_bin || err_count !== 8'(m_err)) begin
                miscompares++;
                $display("FAIL model_cycle t=%0t got v/u/d/s=%b%b%b%b bin=%0d err=%0d want %b%b%b%b bin=%0d err=%0d",
                         $time, valid, up, down, skip_err, bin_out, err_count,
                         m_valid, m_up, m_down, m_skip, m_bin, m_err);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Drive a word, watch 20 cycles; expect a pulse exactly 18 edges later (or none).
    task automatic step(input string name, input logic [7:0] g, input bit exp_v,
                        input int eb, input bit eu, input bit ed, input bit es);
        int seen = -1;
        logic [7:0] cb = 0;
        logic [2:0] cf = 0;
        gray_in = g;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (valid && seen < 0) begin
                seen = c; cb = bin_out; cf = {up, down, skip_err};
            end
        end
        vectors++;
        if (exp_v ? (seen != 18 || cb != 8'(eb) || cf != {eu, ed, es}) : (seen >= 0)) begin
            miscompares++;
            $display("FAIL step_%s got pulse_at=%0d bin=%0d udk=%b want pulse=%0b at 18 bin=%0d udk=%b%b%b",
                     name, seen, cb, cf, exp_v, eb, eu, ed, es);
        end
    endtask

    task automatic idle(input string name, input int n);
        int pulses = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        check(name, pulses, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_bin", int'(bin_out), 0);
        check("reset_valid", int'(valid), 0);
        resetn = 1'b1;

        idle("powerup_no_valid", 40);
        check("powerup_bin", int'(bin_out), 0);
        check("powerup_err", int'(err_count), 0);

        step("up_0_1", 8'h01, 1, 1, 1, 0, 0);
        idle("up_hold", 10);
        check("up_err", int'(err_count), 0);

        step("jump_253", b2g(253), 1, 253, 0, 0, 1);
        step("up_254", b2g(254), 1, 254, 1, 0, 0);
        step("up_255", b2g(255), 1, 255, 1, 0, 0);
        step("wrap_up_0", b2g(0), 1, 0, 1, 0, 0);
        step("up_1", b2g(1), 1, 1, 1, 0, 0);
        step("same_1", b2g(1), 0, 0, 0, 0, 0);
        step("down_0", b2g(0), 1, 0, 0, 1, 0);
        step("wrap_down_255", b2g(255), 1, 255, 0, 1, 0);

        step("to_g03", 8'h03, 1, 2, 0, 0, 1);
        gray_in = 8'h02;
        idle("glitch_on", 10);
        step("glitch_back", 8'h03, 0, 0, 0, 0, 0);
        idle("glitch_settle", 10);
        check("glitch_bin", int'(bin_out), 2);

        step("to_g00", 8'h00, 1, 0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            step("alt_down", 8'h80, 1, 255, 0, 1, 0);
            step("alt_up", 8'h00, 1, 0, 1, 0, 0);
        end
        check("err_before_skips", int'(err_count), 3);
        for (int k = 0; k < 300; k++) begin
            if (k % 2 == 0) step("skip_128", 8'hC0, 1, 128, 0, 0, 1);
            else            step("skip_0", 8'h00, 1, 0, 0, 0, 1);
        end
        check("err_saturated", int'(err_count), 255);

        resetn = 1'b0;
        gray_in = 8'h05;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        idle("nz_first_window", 10);
        resetn = 1'b0;
        #1;
        check("midreset_bin", int'(bin_out), 0);
        check("midreset_err", int'(err_count), 0);
        check("midreset_flags", int'({valid, up, down, skip_err}), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        step("nz_first_accept", 8'h05, 1, 6, 0, 0, 0);
        idle("nz_hold", 20);
        check("nz_err", int'(err_count), 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
